// File: rtl/dmem_access_arbiter_pkg.sv
// Shared definitions for the data-memory access arbiter: FSM states,
// access owner encoding and the read data returned on an aborted access.
package dmem_access_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_DONE_CPU = 2'd2,
    ST_DONE_DBG = 2'd3
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  // Read data handed back to the owner when the memory never acknowledges.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Completion state that belongs to a given access owner.
  function automatic state_e done_state(input owner_e owner);
    return (owner == OWN_DBG) ? ST_DONE_DBG : ST_DONE_CPU;
  endfunction

endpackage

// File: rtl/dmem_access_arbiter.sv
// Data-memory access arbiter: shares one multi-cycle req/ack memory port
// between the CPU MEM stage and a debug/loader port, stalls the pipeline
// until the CPU access completes, and aborts accesses that never get an ack.
module dmem_access_arbiter
  import dmem_access_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  localparam int WAIT_W   = $clog2(TIMEOUT);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [DATA_W-1:0]   ERR_DATA   = DATA_W'(ERR_RDATA);

  state_e              r_state;
  state_e              w_state_nxt;
  owner_e              r_owner;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [STARVE_W-1:0] r_starve_cnt;

  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_cpu_rdata;
  logic [DATA_W-1:0]   r_dbg_rdata;
  logic                r_err;

  logic                w_any_req;
  logic                w_dbg_wins;
  logic                w_grant;
  logic                w_ack;
  logic                w_timeout;
  logic                w_finish;

  // Saturating increment for the starvation counter.
  function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
    return (cnt == STARVE_LIM) ? cnt : cnt + STARVE_W'(1);
  endfunction

  // Debug wins when it is alone, or when the CPU has used up its quota of
  // back-to-back grants while debug was waiting.
  assign w_any_req  = cpu_req_i | dbg_req_i;
  assign w_dbg_wins = dbg_req_i & (~cpu_req_i | (r_starve_cnt == STARVE_LIM));
  assign w_grant    = (r_state == ST_IDLE) & w_any_req;

  // The ack is only meaningful while an access is outstanding; a timeout
  // fires on the last allowed WAIT cycle only if that cycle brings no ack.
  assign w_ack      = (r_state == ST_WAIT) & mem_ack_i;
  assign w_timeout  = (r_state == ST_WAIT) & ~mem_ack_i & (r_wait_cnt == WAIT_LAST);
  assign w_finish   = w_ack | w_timeout;

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign cpu_rdata_o = r_cpu_rdata;
  assign dbg_rdata_o = r_dbg_rdata;
  assign err_o       = r_err;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the state-decoded stall and debug-ack outputs.
  always_comb begin
    w_state_nxt = r_state;
    cpu_stall_o = cpu_req_i;
    dbg_ack_o   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_finish) begin
          w_state_nxt = done_state(r_owner);
        end
      end
      ST_DONE_CPU: begin
        w_state_nxt = ST_IDLE;
        cpu_stall_o = 1'b0;
      end
      ST_DONE_DBG: begin
        w_state_nxt = ST_IDLE;
        dbg_ack_o   = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Starvation counter: counts CPU grants made while debug is waiting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (!dbg_req_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant && w_dbg_wins) begin
      r_starve_cnt <= '0;
    end else if (w_grant) begin
      r_starve_cnt <= starve_inc(r_starve_cnt);
    end
  end

  // Memory request lifecycle: latch the winner on grant, hold it stable
  // through WAIT, then release on ack or timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_owner     <= OWN_CPU;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wait_cnt  <= '0;
    end else if (w_grant) begin
      r_mem_req  <= 1'b1;
      r_wait_cnt <= '0;
      if (w_dbg_wins) begin
        r_owner     <= OWN_DBG;
        r_mem_we    <= dbg_we_i;
        r_mem_addr  <= dbg_addr_i;
        r_mem_wdata <= dbg_wdata_i;
      end else begin
        r_owner     <= OWN_CPU;
        r_mem_we    <= cpu_we_i;
        r_mem_addr  <= cpu_addr_i;
        r_mem_wdata <= cpu_wdata_i;
      end
    end else if (w_finish) begin
      r_mem_req <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  // Owner read-data capture and the sticky timeout flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
      r_err       <= 1'b0;
    end else if (w_ack) begin
      if (r_owner == OWN_DBG) begin
        r_dbg_rdata <= mem_rdata_i;
      end else begin
        r_cpu_rdata <= mem_rdata_i;
      end
    end else if (w_timeout) begin
      r_err <= 1'b1;
      if (r_owner == OWN_DBG) begin
        r_dbg_rdata <= ERR_DATA;
      end else begin
        r_cpu_rdata <= ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Scoreboard bench for dmem_access_arbiter with a latency-programmable
// req/ack memory model.
module tb_dmem_access_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req_i = 1'b0;
  logic          cpu_we_i = 1'b0;
  logic [AW-1:0] cpu_addr_i = '0;
  logic [DW-1:0] cpu_wdata_i = '0;
  logic [DW-1:0] cpu_rdata_o;
  logic          cpu_stall_o;
  logic          dbg_req_i = 1'b0;
  logic          dbg_we_i = 1'b0;
  logic [AW-1:0] dbg_addr_i = '0;
  logic [DW-1:0] dbg_wdata_i = '0;
  logic [DW-1:0] dbg_rdata_o;
  logic          dbg_ack_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_ack_i;
  logic          err_o;

  logic          model_ack = 1'b0;
  logic          stray_ack = 1'b0;
  logic [DW-1:0] model_rdata = 32'hBAD0_0BAD;
  int            lat = 1;
  int            k = 0;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] q_cpu[$];
  logic [31:0] q_dbg[$];
  logic        q_grant[$];
  logic        grant_chk = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];

  assign mem_ack_i   = model_ack | stray_ack;
  assign mem_rdata_i = model_rdata;

  dmem_access_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
    .dbg_wdata_i(dbg_wdata_i), .dbg_rdata_o(dbg_rdata_o), .dbg_ack_o(dbg_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : pat(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: acks `lat` cycles after mem_req_o rises (lat<0: never).
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req_o && !rst) begin
        if (lat >= 0 && k == lat) begin
          model_ack = 1'b1;
          if (mem_we_o) begin
            mem_m[mem_addr_o] = mem_wdata_o;
            model_rdata = 32'h0;
          end else begin
            model_rdata = mem_m.exists(mem_addr_o) ? mem_m[mem_addr_o] : pat(mem_addr_o);
          end
        end else begin
          model_ack   = 1'b0;
          model_rdata = 32'hBAD0_0BAD;
        end
        k++;
      end else begin
        k = 0;
        model_ack   = 1'b0;
        model_rdata = 32'hBAD0_0BAD;
      end
    end
  end

  // Completion / grant monitor: pops the scoreboard queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cpu_req_i && !cpu_stall_o) begin
          chk("cpu_done_expected", 32'(q_cpu.size() != 0), 32'd1);
          if (q_cpu.size() != 0) chk("cpu_rdata", cpu_rdata_o, q_cpu.pop_front());
        end
        if (dbg_ack_o) begin
          chk("dbg_ack_expected", 32'(q_dbg.size() != 0), 32'd1);
          if (q_dbg.size() != 0) chk("dbg_rdata", dbg_rdata_o, q_dbg.pop_front());
          chk("dbg_ack_width", 32'(prev_ack), 32'd0);
        end
        if (grant_chk && mem_req_o && !prev_req) begin
          chk("grant_expected", 32'(q_grant.size() != 0), 32'd1);
          if (q_grant.size() != 0)
            chk("grant_owner", 32'(mem_addr_o == 32'h200), 32'(q_grant.pop_front()));
        end
      end
      prev_req = mem_req_o;
      prev_ack = dbg_ack_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int l, input int exp_stall, input logic [31:0] exp_rd,
                        output int req_cycles);
    int stalls;
    int done;
    req_cycles = 0;
    done = 0;
    lat = l;
    @(negedge clk); #1;
    cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_req_i = 1'b1;
    q_cpu.push_back(exp_rd);
    if (we) ref_m[addr] = wdata;
    #1 stalls = int'(cpu_stall_o);
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk);
      if (mem_req_o) begin
        req_cycles++;
        if (req_cycles == 1) begin
          chk("mem_addr", mem_addr_o, addr);
          chk("mem_we", 32'(mem_we_o), 32'(we));
        end
        if (we) chk("mem_wdata", mem_wdata_o, wdata);
      end
      if (cpu_stall_o) stalls++;
      else done = 1;
    end
    chk("cpu_done_in_time", 32'(done), 32'd1);
    chk("cpu_stall_cycles", 32'(stalls), 32'(exp_stall));
    #1 cpu_req_i = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int l, input logic [31:0] exp_rd);
    int done;
    done = 0;
    lat = l;
    @(negedge clk); #1;
    dbg_we_i = we; dbg_addr_i = addr; dbg_wdata_i = wdata; dbg_req_i = 1'b1;
    q_dbg.push_back(exp_rd);
    if (we) ref_m[addr] = wdata;
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk);
      chk("dbg_no_cpu_stall", 32'(cpu_stall_o), 32'd0);
      if (dbg_ack_o) done = 1;
    end
    chk("dbg_done_in_time", 32'(done), 32'd1);
    #1 dbg_req_i = 1'b0;
  endtask

  initial begin
    int rc;
    int ncpu;
    int stalls;
    int done;

    mem_m[32'h40] = 32'h1234_5678;
    ref_m[32'h40] = 32'h1234_5678;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata_o, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata_o, 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    #1 rst = 1'b0;

    // 1: CPU load, ack one cycle after request rises.
    cpu_op(1'b0, 32'h40, 32'h0, 1, 3, 32'h1234_5678, rc);
    chk("t1_req_cycles", 32'(rc), 32'd2);

    // 2: CPU store acked in the request's first cycle, then read back.
    cpu_op(1'b1, 32'h80, 32'hA5A5_A5A5, 0, 2, 32'h0, rc);
    chk("t2_err", 32'(err_o), 32'd0);
    cpu_op(1'b0, 32'h80, 32'h0, 2, 4, ref_rd(32'h80), rc);

    // 3: both requesting continuously -> four CPU grants, then debug.
    lat = 1;
    grant_chk = 1'b1;
    for (int i = 0; i < 4; i++) q_grant.push_back(1'b0);
    q_grant.push_back(1'b1);
    q_grant.push_back(1'b0);
    for (int i = 0; i < 5; i++) q_cpu.push_back(pat(32'h100));
    q_dbg.push_back(pat(32'h200));
    @(negedge clk); #1;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h100; cpu_req_i = 1'b1;
    dbg_we_i = 1'b0; dbg_addr_i = 32'h200; dbg_req_i = 1'b1;
    ncpu = 0;
    for (int i = 0; i < 100 && ncpu < 5; i++) begin
      @(negedge clk);
      if (dbg_ack_o) #1 dbg_req_i = 1'b0;
      else if (cpu_req_i && !cpu_stall_o) ncpu++;
    end
    chk("t3_cpu_completions", 32'(ncpu), 32'd5);
    #1 cpu_req_i = 1'b0;
    @(negedge clk);
    grant_chk = 1'b0;
    chk("t3_grants_left", 32'(q_grant.size()), 32'd0);

    // 6a: debug read with no CPU op -> never stalls.
    dbg_op(1'b0, 32'h300, 32'h0, 2, pat(32'h300));

    // 6b: CPU request arrives mid-debug access and waits for its own DONE.
    lat = 3;
    @(negedge clk); #1;
    dbg_we_i = 1'b0; dbg_addr_i = 32'h304; dbg_req_i = 1'b1;
    q_dbg.push_back(pat(32'h304));
    @(negedge clk);
    chk("t6_no_stall_before", 32'(cpu_stall_o), 32'd0);
    #1;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h44; cpu_req_i = 1'b1;
    q_cpu.push_back(pat(32'h44));
    #1 stalls = int'(cpu_stall_o);
    done = 0;
    for (int i = 0; i < 60 && done == 0; i++) begin
      @(negedge clk);
      if (dbg_ack_o) #1 dbg_req_i = 1'b0;
      if (cpu_stall_o) stalls++;
      else done = 1;
    end
    chk("t6_cpu_done", 32'(done), 32'd1);
    chk("t6_stall_cycles", 32'(stalls), 32'd10);
    #1 cpu_req_i = 1'b0;

    // 4: no ack -> abort after 16 WAIT cycles, error data, sticky flag.
    cpu_op(1'b0, 32'h500, 32'h0, -1, 17, 32'hDEAD_BEEF, rc);
    chk("t4_req_cycles", 32'(rc), 32'd16);
    chk("t4_err_set", 32'(err_o), 32'd1);
    @(negedge clk); #1 stray_ack = 1'b1;
    @(negedge clk);
    chk("t4_late_ack_req", 32'(mem_req_o), 32'd0);
    chk("t4_late_ack_dbg", 32'(dbg_ack_o), 32'd0);
    #1 stray_ack = 1'b0;
    cpu_op(1'b0, 32'h40, 32'h0, 1, 3, 32'h1234_5678, rc);
    chk("t4_err_sticky", 32'(err_o), 32'd1);

    // 5: reset during a debug write's WAIT.
    lat = -1;
    @(negedge clk); #1;
    dbg_we_i = 1'b1; dbg_addr_i = 32'h600; dbg_wdata_i = 32'h0BAD_F00D; dbg_req_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_in_wait", 32'(mem_req_o), 32'd1);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_req_low", 32'(mem_req_o), 32'd0);
    chk("t5_ack_low", 32'(dbg_ack_o), 32'd0);
    chk("t5_err_clr", 32'(err_o), 32'd0);
    #1;
    rst = 1'b0;
    dbg_req_i = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    chk("t5_late_ack_req", 32'(mem_req_o), 32'd0);
    chk("t5_late_ack_dbg", 32'(dbg_ack_o), 32'd0);
    #1 stray_ack = 1'b0;
    dbg_op(1'b0, 32'h600, 32'h0, 1, ref_rd(32'h600));

    repeat (2) @(negedge clk);
    chk("q_cpu_empty", 32'(q_cpu.size()), 32'd0);
    chk("q_dbg_empty", 32'(q_dbg.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
